// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller (package pipe_pkg).
// Holds the occupancy FSM encoding, the register-0 constant, the IF/ID
// bubble value and the source-operand match helper used by the comparators.
package pipe_pkg;

  typedef enum logic {
    RUN  = 1'b0,
    BUSY = 1'b1
  } md_state_t;

  localparam logic [4:0]  REG_ZERO   = 5'd0;
  localparam logic [31:0] NOP_BUBBLE = 32'hFC000000;

  // True when a producer writing 'wr' feeds a source operand the consumer reads.
  // $0 is hard-wired to zero, so it never creates a dependency.
  function automatic logic src_match(input logic [4:0] wr,
                                     input logic [4:0] rs,
                                     input logic [4:0] rt,
                                     input logic       use_rs,
                                     input logic       use_rt);
    return (wr != REG_ZERO) && ((use_rs && (wr == rs)) || (use_rt && (wr == rt)));
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Signal bundle between the decode-side pipeline and pipe_hazard_ctrl.
// The master side is the pipeline (drives register fields, sees enables);
// the slave side is the hazard controller.
// Optional HAZARD_PERF_CNT_EN adds three 32-bit performance counters.
// Handshake: none; every signal is a level valid for the current cycle and
// sampled on the rising clock edge, outputs are combinational per cycle.
interface pipe_hazard_ctrl_if;
  import pipe_pkg::*;

  logic [4:0] rs_d;
  logic [4:0] rt_d;
  logic       use_rs_d;
  logic       use_rt_d;
  logic       branch_d;
  logic       branch_taken_d;
  logic       hilo_use_d;
  logic [4:0] write_reg_e;
  logic       reg_write_e;
  logic       mem_read_e;
  logic [4:0] write_reg_m;
  logic       mem_read_m;
  logic       md_start_e;
  logic       md_div_e;

  logic       en_pc_n;
  logic       en_a_n;
  logic       clr_a;
  logic       clr_b;
  logic       md_busy;
  logic       md_done;
  md_state_t  md_state;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cycles;
  logic [31:0] flush_cycles;
  logic [31:0] md_ops;
`endif

  modport master (
`ifdef HAZARD_PERF_CNT_EN
    input  stall_cycles, flush_cycles, md_ops,
`endif
    output rs_d, rt_d, use_rs_d, use_rt_d, branch_d, branch_taken_d,
    output hilo_use_d, write_reg_e, reg_write_e, mem_read_e,
    output write_reg_m, mem_read_m, md_start_e, md_div_e,
    input  en_pc_n, en_a_n, clr_a, clr_b, md_busy, md_done, md_state
  );

  modport slave (
`ifdef HAZARD_PERF_CNT_EN
    output stall_cycles, flush_cycles, md_ops,
`endif
    input  rs_d, rt_d, use_rs_d, use_rt_d, branch_d, branch_taken_d,
    input  hilo_use_d, write_reg_e, reg_write_e, mem_read_e,
    input  write_reg_m, mem_read_m, md_start_e, md_div_e,
    output en_pc_n, en_a_n, clr_a, clr_b, md_busy, md_done, md_state
  );

endinterface

// File: rtl/pipe_hazard_ctrl_md_occupancy.sv
// Multiply/divide occupancy tracker (module md_occupancy).
// RUN/BUSY FSM with a down-counter loaded with the op latency minus one.
// busy and done are registered; done is high on the last busy cycle only.
module md_occupancy
  import pipe_pkg::*;
#(
  parameter int MULT_CYCLES = 4,
  parameter int DIV_CYCLES  = 32,
  parameter int CNT_W       = 6
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      md_start,
  input  logic      md_div,
  output logic      busy,
  output logic      done,
  output md_state_t state
);

  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] load_val;

  // Latency of the op entering E; only consumed when a start is accepted.
  always_comb begin
    load_val = md_div ? DIV_LOAD : MULT_LOAD;
  end

  // Occupancy FSM: start only accepted in RUN, count down in BUSY, reset abandons.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          done <= 1'b0;
          if (md_start) begin
            state <= BUSY;
            cnt   <= load_val;
            busy  <= 1'b1;
            done  <= (load_val == '0);
          end
        end
        BUSY: begin
          if (cnt != '0) begin
            cnt  <= cnt - CNT_W'(1);
            done <= (cnt == CNT_W'(1));
          end else begin
            state <= RUN;
            busy  <= 1'b0;
            done  <= 1'b0;
          end
        end
        default: begin
          state <= RUN;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

`ifndef SYNTHESIS
  // A mult/div in D consumes hi/lo and is stalled, so none can start while busy.
  a_no_start_while_busy: assert property (
    @(posedge clk) disable iff (rst) !((state == BUSY) && md_start)
  );
`endif

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard controller for the 5-stage core: sequences the PC, IF/ID and ID/EX
// latches from load-use, branch-operand and hi/lo occupancy hazards.
// Latch enables are active-low; IF/ID gives clear priority over enable, so
// the IF/ID clear is suppressed whenever the pipe stalls.
// Optional feature macro: HAZARD_PERF_CNT_EN (stall/flush/md-op counters).
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int MULT_CYCLES = 4,
  parameter int DIV_CYCLES  = 32,
  parameter int CNT_W       = 6
) (
  input  logic             clk,
  input  logic             rst,
  pipe_hazard_ctrl_if.slave hz
);

  logic      match_e;
  logic      match_m;
  logic      lu_stall;
  logic      br_stall;
  logic      md_stall;
  logic      stall;
  logic      md_busy;
  logic      md_done;
  md_state_t md_state;

  // Dependency comparators and the combined stall term.
  always_comb begin
    match_e  = hz.reg_write_e &
               src_match(hz.write_reg_e, hz.rs_d, hz.rt_d, hz.use_rs_d, hz.use_rt_d);
    match_m  = hz.mem_read_m &
               src_match(hz.write_reg_m, hz.rs_d, hz.rt_d, hz.use_rs_d, hz.use_rt_d);
    lu_stall = hz.mem_read_e & match_e;
    br_stall = hz.branch_d & (match_e | match_m);
    md_stall = md_busy & hz.hilo_use_d;
    stall    = lu_stall | br_stall | md_stall;
  end

  md_occupancy #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES),
    .CNT_W       (CNT_W)
  ) u_md_occupancy (
    .clk      (clk),
    .rst      (rst),
    .md_start (hz.md_start_e),
    .md_div   (hz.md_div_e),
    .busy     (md_busy),
    .done     (md_done),
    .state    (md_state)
  );

  // During reset both latches clear and PC/IF-ID load, flushing in a bubble
  // and a PC+4 of zero; otherwise a stall holds PC/IF-ID and bubbles ID/EX.
  always_comb begin
    hz.en_pc_n  = ~rst & stall;
    hz.en_a_n   = ~rst & stall;
    hz.clr_b    = rst | stall;
    hz.clr_a    = rst | (hz.branch_taken_d & ~stall);
    hz.md_busy  = md_busy;
    hz.md_done  = md_done;
    hz.md_state = md_state;
  end

`ifdef HAZARD_PERF_CNT_EN
  logic md_accept;

  // A start is only taken when the occupancy FSM is idle.
  always_comb begin
    md_accept = hz.md_start_e & (md_state == RUN);
  end

  // Free-running event counters, wrapping modulo 2^32.
  always_ff @(posedge clk) begin
    if (rst) begin
      hz.stall_cycles <= '0;
      hz.flush_cycles <= '0;
      hz.md_ops       <= '0;
    end else begin
      if (stall)     hz.stall_cycles <= hz.stall_cycles + 32'd1;
      if (hz.clr_a)  hz.flush_cycles <= hz.flush_cycles + 32'd1;
      if (md_accept) hz.md_ops       <= hz.md_ops + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl with default parameters
// (MULT_CYCLES=4, DIV_CYCLES=32). Inputs change on the falling edge and
// outputs are checked 1 ns later; state advances on the rising edge.
// Output vector order: {en_pc_n, en_a_n, clr_a, clr_b, md_busy, md_done}.
module tb_pipe_hazard_ctrl;
  import pipe_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  pipe_hazard_ctrl_if hz();

  pipe_hazard_ctrl dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [5:0] outs();
    return {hz.en_pc_n, hz.en_a_n, hz.clr_a, hz.clr_b, hz.md_busy, hz.md_done};
  endfunction

  // Check the current cycle's outputs, then advance to the next falling edge.
  task automatic step(input string tag, input logic [5:0] exp);
    #1;
    chk(tag, {26'd0, outs()}, {26'd0, exp});
    @(negedge clk);
  endtask

  task automatic clr_in();
    hz.rs_d           = 5'd0;
    hz.rt_d           = 5'd0;
    hz.use_rs_d       = 1'b0;
    hz.use_rt_d       = 1'b0;
    hz.branch_d       = 1'b0;
    hz.branch_taken_d = 1'b0;
    hz.hilo_use_d     = 1'b0;
    hz.write_reg_e    = 5'd0;
    hz.reg_write_e    = 1'b0;
    hz.mem_read_e     = 1'b0;
    hz.write_reg_m    = 5'd0;
    hz.mem_read_m     = 1'b0;
    hz.md_start_e     = 1'b0;
    hz.md_div_e       = 1'b0;
  endtask

  initial begin
    // Reset: two edges with rst high, a load-use hazard and a taken branch present.
    rst = 1'b1;
    clr_in();
    hz.mem_read_e = 1'b1; hz.reg_write_e = 1'b1; hz.write_reg_e = 5'd8;
    hz.use_rs_d = 1'b1; hz.rs_d = 5'd8; hz.branch_taken_d = 1'b1;
    repeat (2) @(negedge clk);
    step("reset_outs", 6'b001100);

    rst = 1'b0;
    clr_in();
    step("idle", 6'b000000);
`ifdef HAZARD_PERF_CNT_EN
    chk("perf_rst_stall", hz.stall_cycles, 32'd0);
    chk("perf_rst_flush", hz.flush_cycles, 32'd0);
    chk("perf_rst_mdops", hz.md_ops, 32'd0);
`endif

    // Load-use: lw $8 in E, D reads rs=8 -> one stall cycle.
    hz.mem_read_e = 1'b1; hz.reg_write_e = 1'b1; hz.write_reg_e = 5'd8;
    hz.use_rs_d = 1'b1; hz.rs_d = 5'd8;
    step("lu_stall", 6'b110100);
    // Bubble in E, load now in M; non-branch consumer is forwarded.
    clr_in();
    hz.use_rs_d = 1'b1; hz.rs_d = 5'd8; hz.mem_read_m = 1'b1; hz.write_reg_m = 5'd8;
    step("lu_release", 6'b000000);
`ifdef HAZARD_PERF_CNT_EN
    chk("perf_lu_stall", hz.stall_cycles, 32'd1);
    chk("perf_lu_flush", hz.flush_cycles, 32'd0);
`endif

    // Register zero never matches.
    clr_in();
    hz.mem_read_e = 1'b1; hz.reg_write_e = 1'b1; hz.write_reg_e = 5'd0;
    hz.use_rs_d = 1'b1; hz.rs_d = 5'd0;
    step("reg0_lu", 6'b000000);
    clr_in();
    hz.branch_d = 1'b1; hz.use_rt_d = 1'b1; hz.rt_d = 5'd0;
    hz.mem_read_m = 1'b1; hz.write_reg_m = 5'd0;
    hz.reg_write_e = 1'b1; hz.write_reg_e = 5'd0;
    step("reg0_br", 6'b000000);

    // Use-flag and write-enable gating.
    clr_in();
    hz.mem_read_e = 1'b1; hz.reg_write_e = 1'b1; hz.write_reg_e = 5'd8;
    hz.use_rt_d = 1'b1; hz.rs_d = 5'd8; hz.rt_d = 5'd3;
    step("gate_use_rs", 6'b000000);
    clr_in();
    hz.mem_read_e = 1'b1; hz.reg_write_e = 1'b0; hz.write_reg_e = 5'd8;
    hz.use_rs_d = 1'b1; hz.rs_d = 5'd8;
    step("gate_reg_write", 6'b000000);
    clr_in();
    hz.branch_d = 1'b1; hz.use_rs_d = 1'b1; hz.rs_d = 5'd9;
    hz.write_reg_m = 5'd9; hz.mem_read_m = 1'b0;
    step("gate_mem_read_m", 6'b000000);
    clr_in();
    hz.mem_read_e = 1'b1; hz.reg_write_e = 1'b1; hz.write_reg_e = 5'd12;
    hz.use_rt_d = 1'b1; hz.rt_d = 5'd12;
    step("lu_rt_stall", 6'b110100);

    // Branch operand: ALU writer in E, then load writer in M, then resolves taken.
    clr_in();
    hz.branch_d = 1'b1; hz.branch_taken_d = 1'b1; hz.use_rs_d = 1'b1; hz.rs_d = 5'd9;
    hz.reg_write_e = 1'b1; hz.write_reg_e = 5'd9;
    step("br_stall_e", 6'b110100);
    hz.reg_write_e = 1'b0; hz.write_reg_e = 5'd0;
    hz.mem_read_m = 1'b1; hz.write_reg_m = 5'd9;
    step("br_stall_m", 6'b110100);
    hz.mem_read_m = 1'b0; hz.write_reg_m = 5'd0;
    step("br_taken", 6'b001000);
`ifdef HAZARD_PERF_CNT_EN
    chk("perf_br_stall", hz.stall_cycles, 32'd4);
    chk("perf_br_flush", hz.flush_cycles, 32'd1);
`endif

    // Multiply: busy for 4 cycles, done on the 4th; mflo in D stalls meanwhile.
    clr_in();
    hz.md_start_e = 1'b1;
    step("mul_start", 6'b000000);
    clr_in();
    hz.hilo_use_d = 1'b1;
    step("mul_b1", 6'b110110);
    hz.mem_read_e = 1'b1; hz.reg_write_e = 1'b1; hz.write_reg_e = 5'd4;
    hz.use_rs_d = 1'b1; hz.rs_d = 5'd4;
    step("mul_b2_lu", 6'b110110);
    clr_in();
    hz.hilo_use_d = 1'b1; hz.branch_taken_d = 1'b1;
    step("mul_b3_br", 6'b110110);
    hz.branch_taken_d = 1'b0;
    step("mul_b4_done", 6'b110111);
    step("mul_after", 6'b000000);
    clr_in();
    step("mul_idle", 6'b000000);
`ifdef HAZARD_PERF_CNT_EN
    chk("perf_mul_stall", hz.stall_cycles, 32'd8);
    chk("perf_mul_flush", hz.flush_cycles, 32'd1);
    chk("perf_mul_mdops", hz.md_ops, 32'd1);
`endif

    // Divide, abandoned by reset after 10 busy cycles.
    hz.md_start_e = 1'b1; hz.md_div_e = 1'b1;
    step("div_start", 6'b000000);
    clr_in();
    for (int i = 0; i < 10; i++) step("div_busy", 6'b000010);
    rst = 1'b1;
    step("div_rst", 6'b001110);
    rst = 1'b0;
    for (int i = 0; i < 25; i++) step("div_abandoned", 6'b000000);
`ifdef HAZARD_PERF_CNT_EN
    chk("perf_end_stall", hz.stall_cycles, 32'd0);
    chk("perf_end_flush", hz.flush_cycles, 32'd0);
    chk("perf_end_mdops", hz.md_ops, 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
